// File: rtl/alu_pkg.sv
// Shared ALU encodings: the aluOp classes produced by the main control
// decoder, the R-type function codes, and the aluCtr operation selects
// consumed by the ALU datapath. Every block that touches these fields
// imports this package so the encodings live in exactly one place.
package alu_pkg;

  localparam int FUNC_W = 4;
  localparam int OP_W   = 3;
  localparam int CTR_W  = 3;

  // ALU operation select (aluCtr).
  typedef enum logic [CTR_W-1:0] {
    CTR_ADD = 3'b000,
    CTR_SUB = 3'b001,
    CTR_AND = 3'b010,
    CTR_OR  = 3'b011,
    CTR_XOR = 3'b100,
    CTR_NOR = 3'b101,
    CTR_SLT = 3'b110,
    CTR_SLL = 3'b111
  } alu_ctr_e;

  // Operation class from the main decoder (aluOp).
  typedef enum logic [OP_W-1:0] {
    OP_RTYPE = 3'b000,
    OP_ADD   = 3'b001,
    OP_SUB   = 3'b010,
    OP_AND   = 3'b011,
    OP_OR    = 3'b100,
    OP_SLT   = 3'b101,
    OP_XOR   = 3'b110,
    OP_NOR   = 3'b111
  } alu_op_e;

  // R-type function field codes. Plain constants rather than an enum,
  // because codes 1000-1111 are legal bit patterns on the wire that carry
  // no operation and must still be decoded (as illegal).
  localparam logic [FUNC_W-1:0] FUNC_ADD = 4'b0000;
  localparam logic [FUNC_W-1:0] FUNC_SUB = 4'b0001;
  localparam logic [FUNC_W-1:0] FUNC_AND = 4'b0010;
  localparam logic [FUNC_W-1:0] FUNC_OR  = 4'b0011;
  localparam logic [FUNC_W-1:0] FUNC_XOR = 4'b0100;
  localparam logic [FUNC_W-1:0] FUNC_NOR = 4'b0101;
  localparam logic [FUNC_W-1:0] FUNC_SLT = 4'b0110;
  localparam logic [FUNC_W-1:0] FUNC_SLL = 4'b0111;

endpackage : alu_pkg

// File: rtl/alu_ctrl_decode.sv
// Purely combinational ALU control decoder.
// Ports:
//   func    in  [3:0]  R-type function field (only used when aluOp = R-type)
//   aluOp   in  [2:0]  operation class from the main decoder
//   ctr     out [2:0]  ALU operation select
//   illegal out        R-type function code has no defined operation
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [FUNC_W-1:0] func,
  input  logic [OP_W-1:0]   aluOp,
  output logic [CTR_W-1:0]  ctr,
  output logic              illegal
);

  always_comb begin
    // NOTE: every output gets a value before the case so no path through
    // the decode leaves one unassigned (which would infer a latch).
    ctr     = CTR_ADD;
    illegal = 1'b0;
    case (aluOp)
      OP_RTYPE: begin
        case (func)
          FUNC_ADD: ctr = CTR_ADD;
          FUNC_SUB: ctr = CTR_SUB;
          FUNC_AND: ctr = CTR_AND;
          FUNC_OR:  ctr = CTR_OR;
          FUNC_XOR: ctr = CTR_XOR;
          FUNC_NOR: ctr = CTR_NOR;
          FUNC_SLT: ctr = CTR_SLT;
          FUNC_SLL: ctr = CTR_SLL;
          // Unsupported function codes fall back to a harmless ADD and
          // raise the flag so the exception logic can trap the instruction.
          default: begin
            ctr     = CTR_ADD;
            illegal = 1'b1;
          end
        endcase
      end
      // Non-R-type classes ignore func entirely.
      OP_ADD:  ctr = CTR_ADD;
      OP_SUB:  ctr = CTR_SUB;
      OP_AND:  ctr = CTR_AND;
      OP_OR:   ctr = CTR_OR;
      OP_SLT:  ctr = CTR_SLT;
      OP_XOR:  ctr = CTR_XOR;
      OP_NOR:  ctr = CTR_NOR;
      default: ctr = CTR_ADD;
    endcase
  end

endmodule : alu_ctrl_decode

// File: rtl/alu_control.sv
// ALU control unit: the combinational decoder followed by one output
// register stage, giving exactly one cycle of latency from (aluOp, func)
// to (aluCtr, illegal). Each cycle decodes independently.
// Parameters:
//   RESET_CTR         aluCtr value forced while rstN is low
// Ports:
//   clk      in         rising-edge clock
//   rstN     in         asynchronous active-low reset
//   func     in  [3:0]  R-type function field
//   aluOp    in  [2:0]  operation class from the main decoder
//   aluCtr   out [2:0]  registered ALU operation select
//   illegal  out        registered flag: last sampled R-type func unsupported
module alu_control
  import alu_pkg::*;
#(
  parameter logic [CTR_W-1:0] RESET_CTR = 3'b000
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [FUNC_W-1:0] func,
  input  logic [OP_W-1:0]   aluOp,
  output logic [CTR_W-1:0]  aluCtr,
  output logic              illegal
);

  logic [CTR_W-1:0] dec_ctr;
  logic             dec_illegal;

  logic [CTR_W-1:0] alu_ctr_d, alu_ctr_q;
  logic             illegal_d, illegal_q;

  alu_ctrl_decode u_decode (
    .func    (func),
    .aluOp   (aluOp),
    .ctr     (dec_ctr),
    .illegal (dec_illegal)
  );

  always_comb begin
    alu_ctr_d = dec_ctr;
    illegal_d = dec_illegal;
  end

  always_ff @(posedge clk or negedge rstN) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (!rstN) begin
      alu_ctr_q <= RESET_CTR;
      illegal_q <= 1'b0;
    end else begin
      alu_ctr_q <= alu_ctr_d;
      illegal_q <= illegal_d;
    end
  end

  assign aluCtr  = alu_ctr_q;
  assign illegal = illegal_q;

endmodule : alu_control

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: directed sequences followed by a
// randomized run, all compared against a table-driven reference model.
module tb_alu_control;

  logic       clk;
  logic       rstN;
  logic [3:0] func;
  logic [2:0] aluOp;
  logic [2:0] aluCtr;
  logic       illegal;

  int checks = 0;
  int errors = 0;

  // Reference: ALU select for each non-R-type aluOp class (index 0 unused).
  // Classes 1..7 = ADD, SUB, AND, OR, SLT, XOR, NOR -> 0,1,2,3,6,4,5.
  int op_to_ctr [8] = '{0, 0, 1, 2, 3, 6, 4, 5};

  alu_control #(.RESET_CTR(3'b000)) dut (
    .clk     (clk),
    .rstN    (rstN),
    .func    (func),
    .aluOp   (aluOp),
    .aluCtr  (aluCtr),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] ref_ctr(input logic [2:0] op, input logic [3:0] fn);
    if (op == 3'd0) return (fn < 4'd8) ? fn[2:0] : 3'd0;
    return op_to_ctr[op][2:0];
  endfunction

  function automatic logic ref_ill(input logic [2:0] op, input logic [3:0] fn);
    return (op == 3'd0) && (fn >= 4'd8);
  endfunction

  task automatic check(input string tag, input logic [2:0] exp_ctr, input logic exp_ill);
    checks++;
    assert (aluCtr === exp_ctr && illegal === exp_ill)
    else begin
      errors++;
      $error("FAIL %s: aluCtr=%b illegal=%b, expected aluCtr=%b illegal=%b",
             tag, aluCtr, illegal, exp_ctr, exp_ill);
    end
  endtask

  // Apply inputs mid-cycle, then check just after the next rising edge.
  task automatic step(input logic [2:0] op, input logic [3:0] fn,
                      input logic [2:0] exp_ctr, input logic exp_ill, input string tag);
    @(negedge clk);
    aluOp = op;
    func  = fn;
    @(posedge clk);
    #1;
    check(tag, exp_ctr, exp_ill);
  endtask

  logic [2:0] sweep_op  [8] = '{3'b100, 3'b110, 3'b111, 3'b101, 3'b000, 3'b001, 3'b011, 3'b010};
  logic [2:0] sweep_exp [8] = '{3'b011, 3'b100, 3'b101, 3'b110, 3'b110, 3'b000, 3'b010, 3'b001};

  initial begin
    rstN  = 1'b1;
    aluOp = 3'($urandom);
    func  = 4'($urandom);

    // Reset takes effect immediately, before any clock edge.
    #1 rstN = 1'b0;
    #1 check("reset_async", 3'b000, 1'b0);
    @(posedge clk);
    #1 check("reset_hold", 3'b000, 1'b0);

    @(negedge clk);
    rstN = 1'b1;

    // First edge after release loads the decode of the current inputs.
    step(3'b011, 4'b1111, 3'b010, 1'b0, "first_after_reset");

    // func fixed at SLT, aluOp sweep: func must be ignored except for R-type.
    for (int i = 0; i < 8; i++)
      step(sweep_op[i], 4'b0110, sweep_exp[i], 1'b0, $sformatf("op_sweep_%0d", i));

    // R-type function sweep.
    for (int i = 0; i < 8; i++)
      step(3'b000, 4'(i), 3'(i), 1'b0, $sformatf("func_sweep_%0d", i));

    // Unsupported func, then a non-R-type op clears the flag.
    step(3'b000, 4'b1010, 3'b000, 1'b1, "illegal_func");
    step(3'b010, 4'b1010, 3'b001, 1'b0, "illegal_clear");

    // Hold: changing inputs between edges must not move the outputs.
    step(3'b111, 4'b0000, 3'b101, 1'b0, "hold_setup");
    #2;
    aluOp = 3'b000;
    func  = 4'b1100;
    #1 check("hold_between_edges", 3'b101, 1'b0);
    @(posedge clk);
    #1 check("hold_next_edge", 3'b000, 1'b1);

    // Mid-stream reset discards the registered value at once.
    step(3'b010, 4'b0000, 3'b001, 1'b0, "midreset_setup");
    #2 rstN = 1'b0;
    #1 check("midreset_async", 3'b000, 1'b0);
    @(posedge clk);
    #1 check("midreset_hold", 3'b000, 1'b0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1 check("midreset_release", 3'b001, 1'b0);

    // Randomized run against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic [2:0] op;
      logic [3:0] fn;
      op = 3'($urandom);
      fn = 4'($urandom);
      step(op, fn, ref_ctr(op, fn), ref_ill(op, fn), $sformatf("rand_%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_alu_control
